rampa_pwm_driver: RTL and testbench
===================================

// Module: rampa_pwm_driver
// PURPOSE
//  Consumer end of the soft-start ramp stage lines (30 % / 50 % / 100 %). Decodes the
//  one-hot stage code into a target duty, slews a PWM duty toward it at a fixed rate per
//  PWM period, and drives the motor PWM pin. Flags illegal stage codes as a fault.
//  Sits beside the ramp FSM in the TinyTapeout top; stage lines come from uo_out[2:0].
// PARAMETERS
//  PWM_BITS  8    width of PWM counter and duty; PWM period = 2**PWM_BITS clk cycles
//  STEP      16   duty change applied per PWM period while ramping
//  D30       77   target duty for stage 30
//  D50       128  target duty for stage 50
//  D100      255  target duty for stage 100 (all-ones = continuous high)
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         synchronous active-low reset
//  ena        in   1         enable; low freezes counter/duty/state, forces pwm_out=0
//  stage_30   in   1         stage line 30 %
//  stage_50   in   1         stage line 50 %
//  stage_100  in   1         stage line 100 %
//  pwm_out    out  1         registered PWM output
//  duty       out  PWM_BITS  current applied duty
//  at_target  out  1         high in IDLE or HOLD
//  fault      out  1         high in FAULT
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): counter, duty, target, pwm_out, fault=0; at_target=1; state IDLE.
//  - Stage inputs registered once; decode/target update on the following edge (2-cycle latency).
//  - Code {100,50,30}: 000->target 0; 001->D30; 010->D50; 100->D100; any other -> illegal.
//  - Counter: free-running 0..2**PWM_BITS-1, wraps to 0; increments only when ena=1.
//  - pwm_out (registered) = 1 if duty==all-ones, else (cnt < duty); 0 when ena=0 or FAULT.
//  - Duty update only on wrap cycle (cnt==max, ena=1): duty<target -> min(duty+STEP,target);
//    duty>target -> max(duty-STEP,target); arithmetic saturating, no wrap, PWM_BITS+1 internal.
//  - States: IDLE (target=0,duty=0), RAMP (duty!=target), HOLD (duty==target!=0), FAULT.
//    IDLE->RAMP on legal nonzero code; RAMP->HOLD when duty reaches target;
//    HOLD->RAMP on target change; RAMP/HOLD->IDLE when duty reaches 0 with target 0;
//    any->FAULT on illegal code (registered view); FAULT: duty forced 0 same edge;
//    FAULT->IDLE only after decoded code 000 seen on one edge; stays otherwise.
//  - Target change mid-ramp: new target used at next wrap; direction may reverse.
//  - Reset mid-operation wins over everything, including FAULT.
//  - ena=0: state, duty, counter held; fault detection still runs.
// CONFIGURATION
//  RAMPA_PWM_SOFTSTOP_EN defined: code 000 ramps duty down by STEP per period (RAMP state)
//    until 0, then IDLE.
//  Undefined: code 000 sets duty=0 on the decode edge, state goes directly to IDLE.
// TESTING (defaults PWM_BITS=8, STEP=16)
//  1 Reset: rst_n=0 two cycles -> pwm_out=0, duty=0, fault=0, at_target=1.
//  2 Stage 001 from IDLE -> duty 16,32,48,64,77 on successive wraps; at_target=1 after
//    5th wrap; pwm_out high exactly 77 of 256 cycles per period.
//  3 Then stage 100 -> duty 93..253 then 255 (12 wraps); pwm_out continuously high in HOLD.
//  4 Stage 011 -> fault=1, duty=0 by 2nd edge; pwm_out=0; hold 011 -> stays FAULT;
//    apply 000 -> IDLE, fault=0 within 2 edges.
//  5 Mid-ramp (duty=48) ena=0 for 100 cycles -> duty stays 48, pwm_out=0; ena=1 resumes.
//  6 HOLD at 128, apply 000: with RAMPA_PWM_SOFTSTOP_EN -> 112,96..0 in 8 wraps then IDLE;
//    without -> duty=0 at decode edge, IDLE.

Source files
------------

// File: rtl/rampa_pwm_driver.sv
// Soft-start PWM driver: decodes one-hot ramp stage lines, slews duty per PWM period.
// Optional RAMPA_PWM_SOFTSTOP_EN: code 000 ramps duty down instead of cutting it.
module rampa_pwm_driver #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 16,
  parameter int D30      = 77,
  parameter int D50      = 128,
  parameter int D100     = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                stage_30,
  input  logic                stage_50,
  input  logic                stage_100,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                at_target,
  output logic                fault
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD,
    FAULT
  } state_t;

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS:0]   S_EXT = STEP[PWM_BITS:0];

  state_t              state_q, state_d;
  logic [2:0]          stage_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] tgt_q, tgt_d;
  logic [PWM_BITS-1:0] dec_tgt;
  logic [PWM_BITS-1:0] step_val;
  logic [PWM_BITS:0]   d_ext, t_ext, up, dn;
  logic                dec_ok;
  logic                wrap;
  logic                stop_now;
  logic                pwm_q;

  assign wrap = ena && (cnt_q == MAX);

  always_comb begin
    dec_ok  = 1'b1;
    dec_tgt = '0;
    case (stage_q)
      3'b000:  dec_tgt = '0;
      3'b001:  dec_tgt = D30[PWM_BITS-1:0];
      3'b010:  dec_tgt = D50[PWM_BITS-1:0];
      3'b100:  dec_tgt = D100[PWM_BITS-1:0];
      default: dec_ok  = 1'b0;
    endcase
  end

`ifdef RAMPA_PWM_SOFTSTOP_EN
  assign stop_now = 1'b0;
`else
  assign stop_now = (dec_tgt == '0);
`endif

  // One extra bit keeps duty+STEP from wrapping before the clamp
  always_comb begin
    d_ext    = {1'b0, duty_q};
    t_ext    = {1'b0, tgt_q};
    up       = d_ext + S_EXT;
    dn       = d_ext - S_EXT;
    step_val = duty_q;
    if (d_ext < t_ext) begin
      step_val = (up > t_ext) ? tgt_q : up[PWM_BITS-1:0];
    end else if (d_ext > t_ext) begin
      step_val = (d_ext >= t_ext + S_EXT) ? dn[PWM_BITS-1:0] : tgt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = dec_ok ? dec_tgt : tgt_q;
    if (!dec_ok) begin
      state_d = FAULT;
      duty_d  = '0;
    end else if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (dec_tgt != '0) state_d = RAMP;
        end
        RAMP: begin
          if (stop_now) begin
            state_d = IDLE;
            duty_d  = '0;
          end else if (wrap) begin
            duty_d = step_val;
            if (step_val == tgt_q)
              state_d = (tgt_q == '0) ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (stop_now) begin
            state_d = IDLE;
            duty_d  = '0;
          end else if (tgt_q != duty_q) begin
            state_d = RAMP;
          end
        end
        FAULT: begin
          if (dec_tgt == '0) begin
            state_d = IDLE;
            duty_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= {stage_100, stage_50, stage_30};
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      if (ena) cnt_q <= cnt_q + 1'b1;
      pwm_q <= ena && (state_q != FAULT) &&
               ((duty_q == MAX) || (cnt_q < duty_q));
    end
  end

  assign pwm_out   = pwm_q;
  assign duty      = duty_q;
  assign at_target = (state_q == IDLE) || (state_q == HOLD);
  assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_rampa_pwm_driver.sv
// Bench for rampa_pwm_driver: duty steps go through a scoreboard queue,
// popped whenever the DUT's duty output changes.
module tb_rampa_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       s30 = 1'b0;
  logic       s50 = 1'b0;
  logic       s100 = 1'b0;
  logic       pwm_out;
  logic [7:0] duty;
  logic       at_target;
  logic       fault;

  int total = 0;
  int bad = 0;
  int sb[$];
  int prev = 0;
  int hi;

  always #5 clk = ~clk;

  rampa_pwm_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .stage_30  (s30),
    .stage_50  (s50),
    .stage_100 (s100),
    .pwm_out   (pwm_out),
    .duty      (duty),
    .at_target (at_target),
    .fault     (fault)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (int'(duty) != prev) begin
      if (sb.size() == 0) chk("unexp_duty", int'(duty), prev);
      else chk("duty", int'(duty), sb.pop_front());
      prev = int'(duty);
    end
  end

  task automatic set_stage(input logic [2:0] c);
    {s100, s50, s30} = c;
  endtask

  task automatic push_ramp(input int from, input int to);
    int d = from;
    while (d != to) begin
      if (d < to) d = (d + 16 > to) ? to : d + 16;
      else d = (d - 16 < to) ? to : d - 16;
      sb.push_back(d);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({"timeout_", tag}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic measure(input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      h += int'(pwm_out);
    end
  endtask

  initial begin
    // reset
    repeat (2) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_at", int'(at_target), 1);
    rst_n = 1'b1;

    // stage 30 from idle
    push_ramp(0, 77);
    set_stage(3'b001);
    drain("s30", 8 * 256);
    chk("s30_at", int'(at_target), 1);
    measure(256, hi);
    chk("s30_hi", hi, 77);

    // stage 100
    push_ramp(77, 255);
    chk("s100_len", sb.size(), 12);
    set_stage(3'b100);
    drain("s100", 16 * 256);
    repeat (2) @(negedge clk);
    chk("s100_at", int'(at_target), 1);
    measure(256, hi);
    chk("s100_hi", hi, 256);

    // illegal code
    sb.push_back(0);
    set_stage(3'b011);
    repeat (2) @(posedge clk);
    #1;
    chk("flt_set", int'(fault), 1);
    chk("flt_duty", int'(duty), 0);
    @(negedge clk);
    measure(300, hi);
    chk("flt_pwm", hi, 0);
    chk("flt_hold", int'(fault), 1);
    @(negedge clk);
    set_stage(3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("flt_clr", int'(fault), 0);
    chk("flt_at", int'(at_target), 1);

    // ena freeze mid-ramp
    @(negedge clk);
    push_ramp(0, 48);
    set_stage(3'b001);
    drain("frz", 6 * 256);
    ena = 1'b0;
    chk("frz_at", int'(at_target), 0);
    measure(100, hi);
    chk("frz_pwm", hi, 0);
    chk("frz_duty", int'(duty), 48);
    ena = 1'b1;
    push_ramp(48, 77);
    drain("frz_res", 4 * 256);
    chk("frz_done", int'(at_target), 1);

    // hold at 128 then stop
    push_ramp(77, 128);
    set_stage(3'b010);
    drain("s50", 6 * 256);
    repeat (2) @(negedge clk);
    chk("s50_at", int'(at_target), 1);
`ifdef RAMPA_PWM_SOFTSTOP_EN
    push_ramp(128, 0);
    chk("stop_len", sb.size(), 8);
    set_stage(3'b000);
    drain("stop", 12 * 256);
    repeat (2) @(negedge clk);
`else
    sb.push_back(0);
    set_stage(3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("stop_duty", int'(duty), 0);
`endif
    chk("stop_at", int'(at_target), 1);
    chk("stop_flt", int'(fault), 0);

    // reset wins over fault
    @(negedge clk);
    set_stage(3'b101);
    repeat (2) @(posedge clk);
    #1;
    chk("rf_set", int'(fault), 1);
    @(negedge clk);
    rst_n = 1'b0;
    set_stage(3'b000);
    @(posedge clk);
    #1;
    chk("rf_fault", int'(fault), 0);
    chk("rf_at", int'(at_target), 1);
    chk("rf_duty", int'(duty), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rf_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
